// File: rtl/ddc_out_stage.sv
`timescale 1ns/1ps
// ddc_out_stage
// Back end of the DDC chain. Each decimated I/Q sample is scaled by a signed
// gain, saturated back to WIDTH bits, rounded to 16-bit (sc16) or 8-bit (sc8)
// precision with symmetric clamping, and packed into a 32-bit output word.
// In sc8 mode two consecutive complex samples share one output word.
//
// Ports:
//   clk        DSP clock
//   rst        synchronous active-high reset
//   clr        synchronous clear of the sc8 pairing phase and the overflow counter
//   set_stb    settings strobe; set_addr/set_data select and carry the value
//              BASE+0 : scale[SWIDTH-1:0] (signed, unity = 0x10000)
//              BASE+1 : mode[0] (1 = sc8), data[31] clears ovf_count
//   in_i/in_q  decimated I/Q (two's complement), valid when in_stb is high
//   sample     packed output word, holds between strobes
//   strobe     single-cycle output word valid, 3 cycles after the (last) input
//   ovf_count  saturating count of samples that clamped anywhere
module ddc_out_stage #(
    parameter int BASE   = 0,
    parameter int WIDTH  = 24,
    parameter int SWIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] in_i,
    input  logic [WIDTH-1:0] in_q,
    input  logic             in_stb,
    output logic [31:0]      sample,
    output logic             strobe,
    output logic [15:0]      ovf_count
);
    localparam logic [7:0] ADDR_SCALE = 8'(BASE);
    localparam logic [7:0] ADDR_MODE  = 8'(BASE + 1);

    // Symmetric WIDTH-bit saturation limits
    localparam logic signed [WIDTH-1:0] V_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] V_MIN = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

    // Half-LSB rounding offsets for the two output precisions
    localparam logic signed [WIDTH:0] RND16 = {17'b0, 1'b1, {(WIDTH-17){1'b0}}};
    localparam logic signed [WIDTH:0] RND8  = {9'b0, 1'b1, {(WIDTH-9){1'b0}}};
    localparam logic signed [WIDTH:0] LIM16 = (WIDTH+1)'(32'sd32767);
    localparam logic signed [WIDTH:0] LIM8  = (WIDTH+1)'(32'sd127);

    // Top 18 input bits times the scale, kept to 36 bits
    function automatic logic signed [35:0] mul36(input logic signed [17:0] a,
                                                 input logic signed [SWIDTH-1:0] b);
        logic signed [35:0] ae;
        logic signed [35:0] be;
        ae = 36'(a);
        be = 36'(b);
        return ae * be;
    endfunction

    // Gain select: {flag, V}; saturates when the bits above the window disagree
    function automatic logic [WIDTH:0] gain_sel(input logic signed [35:0] p);
        logic [WIDTH:0] res;
        if ((p[35] == p[34]) && (p[34] == p[33])) begin
            res = {1'b0, p[33 -: WIDTH]};
        end else if (p[35]) begin
            res = {1'b1, V_MIN};
        end else begin
            res = {1'b1, V_MAX};
        end
        return res;
    endfunction

    // Round half up to 8 or 16 bits and clamp symmetrically: {flag, R}
    function automatic logic [16:0] round_sat(input logic signed [WIDTH-1:0] v,
                                              input logic sc8);
        logic signed [WIDTH:0] ve;
        logic signed [WIDTH:0] r;
        logic signed [WIDTH:0] lim;
        logic [16:0]           res;
        ve = (WIDTH+1)'(v);
        if (sc8) begin
            r   = (ve + RND8) >>> (WIDTH - 8);
            lim = LIM8;
        end else begin
            r   = (ve + RND16) >>> (WIDTH - 16);
            lim = LIM16;
        end
        if (r > lim) begin
            res = {1'b1, 16'(lim)};
        end else if (r < -lim) begin
            res = {1'b1, 16'(-lim)};
        end else begin
            res = {1'b0, 16'(r)};
        end
        return res;
    endfunction

    logic signed [SWIDTH-1:0] scale_r;
    logic                     mode_r;
    logic                     s1_vld_r;
    logic signed [35:0]       p_i_r;
    logic signed [35:0]       p_q_r;
    logic                     s2_vld_r;
    logic                     s2_flag_r;
    logic signed [WIDTH-1:0]  v_i_r;
    logic signed [WIDTH-1:0]  v_q_r;
    logic                     phase_r;
    logic [15:0]              hold_r;
    logic [31:0]              sample_r;
    logic                     strobe_r;
    logic [15:0]              ovf_r;

    logic        wr_scale_s;
    logic        wr_mode_s;
    logic        ovf_clr_s;
    logic        phase_clr_s;
    logic [WIDTH:0] g_i_s;
    logic [WIDTH:0] g_q_s;
    logic [16:0] r_i_s;
    logic [16:0] r_q_s;
    logic        flag_s;
    logic        phase_eff_s;
    logic        unused_ok_s;

    assign wr_scale_s  = set_stb && (set_addr == ADDR_SCALE);
    assign wr_mode_s   = set_stb && (set_addr == ADDR_MODE);
    assign ovf_clr_s   = clr || (wr_mode_s && set_data[31]);
    assign phase_clr_s = clr || wr_mode_s;
    assign unused_ok_s = ^{set_data, in_i, in_q};

    // Settings registers
    always_ff @(posedge clk) begin
        if (rst) begin
            scale_r <= '0;
            mode_r  <= 1'b0;
        end else begin
            if (wr_scale_s) begin
                scale_r <= set_data[SWIDTH-1:0];
            end
            if (wr_mode_s) begin
                mode_r <= set_data[0];
            end
        end
    end

    // S1: multiply the top 18 input bits by the current scale
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_r <= 1'b0;
            p_i_r    <= '0;
            p_q_r    <= '0;
        end else begin
            s1_vld_r <= in_stb;
            if (in_stb) begin
                p_i_r <= mul36(in_i[WIDTH-1 -: 18], scale_r);
                p_q_r <= mul36(in_q[WIDTH-1 -: 18], scale_r);
            end
        end
    end

    // Gain-select and rounding results feeding the next registers
    always_comb begin
        g_i_s  = gain_sel(p_i_r);
        g_q_s  = gain_sel(p_q_r);
        r_i_s  = round_sat(v_i_r, mode_r);
        r_q_s  = round_sat(v_q_r, mode_r);
        flag_s = s2_flag_r | r_i_s[16] | r_q_s[16];
        // A pending clear discards the held half-word before this sample lands
        if (phase_clr_s) begin
            phase_eff_s = 1'b0;
        end else begin
            phase_eff_s = phase_r;
        end
    end

    // S2: window the product to WIDTH bits with saturation
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld_r  <= 1'b0;
            s2_flag_r <= 1'b0;
            v_i_r     <= '0;
            v_q_r     <= '0;
        end else begin
            s2_vld_r <= s1_vld_r;
            if (s1_vld_r) begin
                s2_flag_r <= g_i_s[WIDTH] | g_q_s[WIDTH];
                v_i_r     <= g_i_s[WIDTH-1:0];
                v_q_r     <= g_q_s[WIDTH-1:0];
            end
        end
    end

    // S3: round, pack and present the output word
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_r <= '0;
            strobe_r <= 1'b0;
            phase_r  <= 1'b0;
            hold_r   <= '0;
        end else begin
            strobe_r <= 1'b0;
            if (phase_clr_s) begin
                phase_r <= 1'b0;
            end
            if (s2_vld_r) begin
                if (!mode_r) begin
                    sample_r <= {r_i_s[15:0], r_q_s[15:0]};
                    strobe_r <= 1'b1;
                end else if (!phase_eff_s) begin
                    hold_r  <= {r_i_s[7:0], r_q_s[7:0]};
                    phase_r <= 1'b1;
                end else begin
                    sample_r <= {hold_r, r_i_s[7:0], r_q_s[7:0]};
                    strobe_r <= 1'b1;
                    phase_r  <= 1'b0;
                end
            end
        end
    end

    // Overflow counter: one count per flagged sample, sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 16'h0000;
        end else if (ovf_clr_s) begin
            ovf_r <= 16'h0000;
        end else if (s2_vld_r && flag_s && (ovf_r != 16'hFFFF)) begin
            ovf_r <= ovf_r + 16'h0001;
        end
    end

    assign sample    = sample_r;
    assign strobe    = strobe_r;
    assign ovf_count = ovf_r;

endmodule

// File: tb/tb_ddc_out_stage.sv
`timescale 1ns/1ps
// Scoreboard bench for ddc_out_stage: stimulus pushes expected words computed
// by an arithmetic reference model; a negedge monitor pops and compares.
module tb_ddc_out_stage;
    localparam int BASE = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [23:0] in_i;
    logic [23:0] in_q;
    logic        in_stb;
    logic [31:0] sample;
    logic        strobe;
    logic [15:0] ovf_count;

    ddc_out_stage #(.BASE(BASE), .WIDTH(24), .SWIDTH(18)) dut (
        .clk(clk), .rst(rst), .clr(clr), .set_stb(set_stb), .set_addr(set_addr),
        .set_data(set_data), .in_i(in_i), .in_q(in_q), .in_stb(in_stb),
        .sample(sample), .strobe(strobe), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_push = 0;
    int n_strobe = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] w;
        logic [15:0] ovf;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // reference model state
    longint      mscale = 0;
    bit          mmode = 1'b0;
    int          movf = 0;
    bit          mphase = 1'b0;
    logic [15:0] mhold = 16'h0;

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
        end
    endtask

    // monitor: every strobe must match the oldest expected word
    always @(negedge clk) begin
        if (!rst && strobe) begin
            n_strobe++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe actual sample=0x%08h expected no strobe", sample);
            end else begin
                mon_e = sb.pop_front();
                check("sample", sample, mon_e.w);
                check("ovf_at_strobe", ovf_count, mon_e.ovf);
                check("latency_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // arithmetic model of one component: returns {flag, R[15:0]}
    function automatic logic [16:0] model_round(input logic [23:0] x, input bit sc8);
        longint xs, a, p, v, r, lim;
        int ow;
        bit flag;
        logic [16:0] res;
        flag = 1'b0;
        xs = longint'(x);
        if (xs >= 64'sd8388608) xs = xs - 64'sd16777216;
        a = xs >>> 6;
        p = a * mscale;
        if (p >= 64'sd8589934592 || p < -64'sd8589934592) begin
            flag = 1'b1;
            v = (p < 0) ? -64'sd8388607 : 64'sd8388607;
        end else begin
            v = p >>> 10;
        end
        ow = sc8 ? 8 : 16;
        r = (v + (64'sd1 <<< (23 - ow))) >>> (24 - ow);
        lim = (64'sd1 <<< (ow - 1)) - 64'sd1;
        if (r > lim) begin
            r = lim;
            flag = 1'b1;
        end else if (r < -lim) begin
            r = -lim;
            flag = 1'b1;
        end
        res = {flag, r[15:0]};
        return res;
    endfunction

    task automatic push_exp(input logic [31:0] w);
        exp_t e;
        e.w = w;
        e.ovf = movf[15:0];
        e.cyc = cyc + 3;
        sb.push_back(e);
        n_push++;
    endtask

    // issue one sample on the next negedge; clr_hit means a clear lands with it in S3
    task automatic send(input logic [23:0] i, input logic [23:0] q, input bit clr_hit);
        logic [16:0] ri, rq;
        @(negedge clk);
        in_i = i;
        in_q = q;
        in_stb = 1'b1;
        ri = model_round(i, mmode);
        rq = model_round(q, mmode);
        if ((ri[16] || rq[16]) && movf < 65535) movf++;
        if (clr_hit) begin
            movf = 0;
            mphase = 1'b0;
        end
        if (!mmode) begin
            push_exp({ri[15:0], rq[15:0]});
        end else if (!mphase) begin
            mhold = {ri[7:0], rq[7:0]};
            mphase = 1'b1;
        end else begin
            push_exp({mhold, ri[7:0], rq[7:0]});
            mphase = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_stb = 1'b0;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic signed [17:0] s;
        @(negedge clk);
        in_stb = 1'b0;
        set_stb = 1'b1;
        set_addr = a;
        set_data = d;
        if (a == 8'(BASE)) begin
            s = d[17:0];
            mscale = s;
        end else if (a == 8'(BASE + 1)) begin
            mmode = d[0];
            mphase = 1'b0;
            if (d[31]) movf = 0;
        end
        @(negedge clk);
        set_stb = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        in_stb = 1'b0;
        clr = 1'b1;
        movf = 0;
        mphase = 1'b0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    function automatic logic [23:0] rand_val();
        logic [23:0] v;
        case ($urandom_range(0, 7))
            0: v = 24'h7FFFFF;
            1: v = 24'h800000;
            2: v = 24'h7FFFC0;
            3: v = 24'h800040;
            default: v = 24'($urandom);
        endcase
        return v;
    endfunction

    function automatic logic [31:0] rand_scale();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0001_0000;
            1: v = 32'h0001_8000;
            2: v = 32'h0002_0000;
            3: v = 32'h0003_FFFF;
            default: v = {14'h0, 18'($urandom)};
        endcase
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=time limit reached expected=run complete");
        $fatal(1, "timeout");
    end

    initial begin
        int need;
        rst = 1'b1; clr = 1'b0; set_stb = 1'b0; set_addr = 8'h0; set_data = 32'h0;
        in_i = 24'h0; in_q = 24'h0; in_stb = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_sample", sample, 32'h0);
        check("reset_strobe", strobe, 1'b0);
        check("reset_ovf", ovf_count, 16'h0);
        rst = 1'b0;

        // unity gain sc16
        wr(8'(BASE), 32'h0001_0000);
        wr(8'(BASE + 1), 32'h0);
        send(24'h123456, 24'hFFFF00, 1'b0);
        idle(6);
        check("ovf_unity", ovf_count, movf);

        // S2 saturation on both components
        wr(8'(BASE), 32'h0001_8000);
        send(24'h7FFFC0, 24'h800000, 1'b0);
        idle(6);
        check("ovf_s2_sat", ovf_count, movf);

        // S3-only clamp
        wr(8'(BASE), 32'h0001_0000);
        send(24'h7FFFC0, 24'h000000, 1'b0);
        idle(6);
        check("ovf_s3_clamp", ovf_count, movf);

        // sc8 pairing, spaced then back-to-back
        wr(8'(BASE + 1), 32'h1);
        send(24'h123456, 24'hFEDCBA, 1'b0);
        idle(4);
        check("sc8_no_strobe_after_first", n_strobe, n_push);
        send(24'h400000, 24'hC00000, 1'b0);
        idle(6);
        send(24'h123456, 24'hFEDCBA, 1'b0);
        send(24'h400000, 24'hC00000, 1'b0);
        idle(6);
        check("sc8_pair_count", n_strobe, n_push);

        // held half-word dropped by a mode write, then by clr
        send(24'h111111, 24'h222222, 1'b0);
        idle(4);
        wr(8'(BASE + 1), 32'h1);
        send(24'h333333, 24'h444444, 1'b0);
        send(24'h555555, 24'h666666, 1'b0);
        idle(6);
        send(24'h777777, 24'h888888, 1'b0);
        idle(4);
        pulse_clr();
        send(24'h999999, 24'hAAAAAA, 1'b0);
        send(24'hBBBBBB, 24'hCCCCCC, 1'b0);
        idle(6);
        check("sc8_discard_count", n_strobe, n_push);

        // randomized blocks with setting changes between them
        for (int b = 0; b < 12; b++) begin
            idle(4);
            wr(8'(BASE), rand_scale());
            wr(8'(BASE + 1), {($urandom_range(0, 3) == 0), 30'h0, 1'($urandom)});
            for (int k = 0; k < 120; k++) begin
                send(rand_val(), rand_val(), 1'b0);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
            idle(6);
            check("rand_ovf", ovf_count, movf);
            check("rand_count", n_strobe, n_push);
        end

        // drive the counter into saturation
        wr(8'(BASE + 1), 32'h0);
        wr(8'(BASE), 32'h0001_8000);
        need = 65535 - movf + 5;
        for (int k = 0; k < need; k++) send(24'h7FFFC0, 24'h800000, 1'b0);
        idle(6);
        check("ovf_hold_model", ovf_count, movf);
        check("ovf_hold_ffff", ovf_count, 16'hFFFF);

        // clr coinciding with a flagged sample in S3
        send(24'h7FFFC0, 24'h000000, 1'b1);
        @(negedge clk); in_stb = 1'b0;
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        idle(4);
        check("clr_priority", ovf_count, 16'h0);

        // rst while a sample is in S1, then in S2
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            in_i = 24'h123456; in_q = 24'h654321; in_stb = 1'b1;
            @(negedge clk);
            in_stb = 1'b0;
            if (d == 1) @(negedge clk);
            rst = 1'b1;
            mscale = 0; mmode = 1'b0; movf = 0; mphase = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            idle(8);
            check("rst_no_strobe", n_strobe, n_push);
            check("rst_sample", sample, 32'h0);
            check("rst_ovf", ovf_count, 16'h0);
        end

        // pipeline alive after reset
        wr(8'(BASE), 32'h0001_0000);
        send(24'h123456, 24'hFFFF00, 1'b0);
        idle(4);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        check("final_count", n_strobe, n_push);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
